// File: rtl/count_updown_mod_pkg.sv
// Shared encodings for the up/down modulo counter.
package counter_pkg;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;
    localparam logic DIR_DN    = 1'b0;
    localparam logic DIR_UP    = 1'b1;
endpackage

// File: rtl/count_updown_mod_prescaler.sv
// Clock-enable divider: one tick per (prescale+1) enabled cycles.
module count_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);
    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] pre_cnt;

    // >= so a prescale lowered below pre_cnt ticks at once instead of waiting for wrap
    assign tick = enable && (pre_cnt >= prescale);

    always_ff @(posedge clk) begin
        if (rst || clr)
            pre_cnt <= '0;
        else if (enable)
            pre_cnt <= tick ? '0 : pre_cnt + ONE;
    end
endmodule

// File: rtl/count_updown_mod.sv
// Up/down modulo counter with programmable limit, wrap/saturate, load, prescaler, tc and sticky ovf.
module count_updown_mod
    import counter_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  up_dn,
    input  logic                  mode,
    input  logic [WIDTH-1:0]      limit,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  ovf_clr,
    output logic [WIDTH-1:0]      count_out,
    output logic                  tc,
    output logic                  ovf
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic             tick;
    logic [WIDTH-1:0] nxt_cnt;
    logic [WIDTH-1:0] load_cnt;
    logic             nxt_tc;
    logic             ovf_set;

    count_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .clr      (load),
        .prescale (prescale),
        .tick     (tick)
    );

    assign load_cnt = (load_val > limit) ? limit : load_val;

    always_comb begin
        nxt_cnt = count_out;
        nxt_tc  = 1'b0;
        ovf_set = 1'b0;
        if (tick) begin
            if (up_dn == DIR_UP) begin
                if (count_out < limit) begin
                    nxt_cnt = count_out + ONE;
                    nxt_tc  = (mode == MODE_SAT) && (nxt_cnt == limit);
                end else if (mode == MODE_WRAP) begin
                    nxt_cnt = '0;
                    nxt_tc  = 1'b1;
                    ovf_set = 1'b1;
                end else begin
                    // covers a count stranded above a newly lowered limit
                    nxt_cnt = limit;
                    ovf_set = 1'b1;
                end
            end else begin
                if (count_out == '0) begin
                    nxt_cnt = (mode == MODE_WRAP) ? limit : '0;
                    nxt_tc  = (mode == MODE_WRAP);
                    ovf_set = 1'b1;
                end else begin
                    nxt_cnt = (count_out > limit) ? limit : count_out - ONE;
                    nxt_tc  = (mode == MODE_SAT) && (nxt_cnt == '0);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_out <= '0;
            tc        <= 1'b0;
            ovf       <= 1'b0;
        end else if (load) begin
            count_out <= load_cnt;
            tc        <= 1'b0;
            ovf       <= ovf & ~ovf_clr;
        end else begin
            count_out <= nxt_cnt;
            tc        <= nxt_tc;
            ovf       <= ovf_set | (ovf & ~ovf_clr);
        end
    end
endmodule
